pipelined_left_shifter: RTL and testbench

//  Registered left-direction barrel shifter; the counterpart to the team's combinational right shifter.

---
 rtl/pipelined_left_shifter.sv | 136 +++++++++++++
 tb/tb_pipelined_left_shifter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_left_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_left_shifter
//   Registered left barrel shifter/rotator. A WIDTH-bit operand moves through
//   SHW registered mux stages. The first stage applies the largest power-of-two
//   shift (MSB of the shift amount) and the last stage applies a shift of 1.
//   One operand can enter per enabled cycle, and its result appears SHW enabled
//   cycles later. In logical mode the block also reports the last bit shifted
//   out (carry) and the OR of every bit shifted out (sticky overflow).
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous reset, active-high (overrides en_i)
//   en_i         pipeline advance; 0 = every register holds
//   in_valid_i   d_i/shift_i/rot_i carry a valid operand this cycle
//   d_i          operand
//   shift_i      left shift amount, 0..WIDTH-1
//   rot_i        1 = rotate left, 0 = logical left with zero fill
//   out_valid_o  out_o/carry_o/ovf_o hold a new result this cycle
//   out_o        shifted/rotated result (holds the last result between valids)
//   carry_o      logical mode: last bit shifted out; rotate: 0
//   ovf_o        logical mode: OR of all bits shifted out; rotate: 0
// -----------------------------------------------------------------------------
module pipelined_left_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [SHW-1:0]   shift_i,
    input  logic             rot_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_o,
    output logic             carry_o,
    output logic             ovf_o
);

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        // Shift amount handled by this stage: MSB-first, so WIDTH/2 down to 1.
        localparam int S = 1 << (SHW - 1 - k);

        // Stage inputs. Only the shift bits that have not yet been applied
        // travel down the pipe, so stage k sees SHW-k of them.
        logic             v_in;
        logic [WIDTH-1:0] x_in;
        logic             c_in;
        logic             o_in;
        logic [SHW-1-k:0] sh_in;
        logic             r_in;

        logic [WIDTH-1:0] x_d;
        logic             c_d;
        logic             o_d;

        logic             v_q;
        logic [WIDTH-1:0] x_q;
        logic             c_q;
        logic             o_q;

        if (k == 0) begin : g_first
            assign v_in  = in_valid_i;
            assign x_in  = d_i;
            assign c_in  = 1'b0;
            assign o_in  = 1'b0;
            assign sh_in = shift_i;
            assign r_in  = rot_i;
        end else begin : g_next
            assign v_in  = g_stage[k-1].v_q;
            assign x_in  = g_stage[k-1].x_q;
            assign c_in  = g_stage[k-1].c_q;
            assign o_in  = g_stage[k-1].o_q;
            assign sh_in = g_stage[k-1].g_fwd.sh_q;
            assign r_in  = g_stage[k-1].g_fwd.rot_q;
        end

        always_comb begin
            x_d = x_in;
            c_d = c_in;
            o_d = o_in;
            if (sh_in[SHW-1-k]) begin
                if (r_in) begin
                    x_d = {x_in[WIDTH-1-S:0], x_in[WIDTH-1:WIDTH-S]};
                    c_d = 1'b0;
                    o_d = 1'b0;
                end else begin
                    x_d = x_in << S;
                    c_d = x_in[WIDTH-S];
                    o_d = o_in | (|x_in[WIDTH-1:WIDTH-S]);
                end
            end
        end

        // Data and flags load only with a valid operand, so bubbles leave the
        // previous result in place.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v_q <= 1'b0;
                x_q <= '0;
                c_q <= 1'b0;
                o_q <= 1'b0;
            end else if (en_i) begin
                v_q <= v_in;
                if (v_in) begin
                    x_q <= x_d;
                    c_q <= c_d;
                    o_q <= o_d;
                end
            end
        end

        // The remaining shift bits and the mode are forwarded to all stages
        // except the last one, whose output needs neither.
        if (k < SHW - 1) begin : g_fwd
            logic [SHW-2-k:0] sh_q;
            logic             rot_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sh_q  <= '0;
                    rot_q <= 1'b0;
                end else if (en_i && v_in) begin
                    sh_q  <= sh_in[SHW-2-k:0];
                    rot_q <= r_in;
                end
            end
        end
    end

    assign out_valid_o = g_stage[SHW-1].v_q;
    assign out_o       = g_stage[SHW-1].x_q;
    assign carry_o     = g_stage[SHW-1].c_q;
    assign ovf_o       = g_stage[SHW-1].o_q;

endmodule

// File: tb/tb_pipelined_left_shifter.sv
module tb_pipelined_left_shifter;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             en_i;
    logic             in_valid_i;
    logic [WIDTH-1:0] d_i;
    logic [SHW-1:0]   shift_i;
    logic             rot_i;
    logic             out_valid_o;
    logic [WIDTH-1:0] out_o;
    logic             carry_o;
    logic             ovf_o;

    pipelined_left_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .in_valid_i  (in_valid_i),
        .d_i         (d_i),
        .shift_i     (shift_i),
        .rot_i       (rot_i),
        .out_valid_o (out_valid_o),
        .out_o       (out_o),
        .carry_o     (carry_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             c;
        logic             o;
        int               tag;   // enabled-edge count at which the result must appear
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   sh;
        logic             rot;
        logic [WIDTH-1:0] out;
        logic             c;
        logic             o;
    } vec_t;

    exp_t             sb[$];
    int               n_vec  = 0;
    int               n_fail = 0;
    int               en_edges = 0;
    logic             edge_en;
    logic             edge_rst;
    logic [WIDTH-1:0] last_out = '0;
    logic             last_c   = 1'b0;
    logic             last_o   = 1'b0;

    // Reference: shift into a double-width word; the upper half is what fell out.
    function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                                   input logic rot);
        exp_t             e;
        logic [2*WIDTH-1:0] w;
        w = {{WIDTH{1'b0}}, d} << sh;
        e.tag = 0;
        if (rot) begin
            e.out = w[WIDTH-1:0] | w[2*WIDTH-1:WIDTH];
            e.c   = 1'b0;
            e.o   = 1'b0;
        end else begin
            e.out = w[WIDTH-1:0];
            e.c   = (sh == 0) ? 1'b0 : w[WIDTH];
            e.o   = |w[2*WIDTH-1:WIDTH];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample control at the rising edge, check outputs at the falling edge.
    task automatic tick();
        exp_t e;
        @(posedge clk_i);
        edge_en  = en_i && !rst_i;
        edge_rst = rst_i;
        if (edge_en) en_edges++;
        @(negedge clk_i);
        if (edge_rst) begin
            sb.delete();
            last_out = '0;
            last_c   = 1'b0;
            last_o   = 1'b0;
        end
        if (edge_en) begin
            n_vec++;
            if (out_valid_o) begin
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: got out_valid=1 out=%0h, expected no result", out_o);
                end else begin
                    e = sb.pop_front();
                    if (out_o !== e.out || carry_o !== e.c || ovf_o !== e.o || en_edges != e.tag) begin
                        n_fail++;
                        $display("FAIL result: got out=%0h c=%0b o=%0b at edge %0d, expected out=%0h c=%0b o=%0b at edge %0d",
                                 out_o, carry_o, ovf_o, en_edges, e.out, e.c, e.o, e.tag);
                    end
                end
                last_out = out_o;
                last_c   = carry_o;
                last_o   = ovf_o;
            end else if (out_o !== last_out || carry_o !== last_c || ovf_o !== last_o) begin
                n_fail++;
                $display("FAIL hold: got out=%0h c=%0b o=%0b, expected out=%0h c=%0b o=%0b",
                         out_o, carry_o, ovf_o, last_out, last_c, last_o);
            end
        end
    endtask

    task automatic drive_x(input logic v, input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                           input logic r, input logic en, input exp_t ex);
        exp_t e;
        in_valid_i = v;
        d_i        = d;
        shift_i    = sh;
        rot_i      = r;
        en_i       = en;
        if (v && en && !rst_i) begin
            e     = ex;
            e.tag = en_edges + SHW;
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                         input logic r, input logic en);
        drive_x(v, d, sh, r, en, model(d, sh, r));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, WIDTH'($urandom), SHW'($urandom), 1'b0, 1'b1);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{8'hB3, 3'd3, 1'b0, 8'h98, 1'b1, 1'b1};
        vecs[1] = '{8'hB3, 3'd3, 1'b1, 8'h9D, 1'b0, 1'b0};
        vecs[2] = '{8'h81, 3'd1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 3'd7, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h5A, 3'd0, 1'b0, 8'h5A, 1'b0, 1'b0};
        vecs[5] = '{8'h0F, 3'd4, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{8'h40, 3'd1, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[8] = '{8'h12, 3'd5, 1'b1, 8'h42, 1'b0, 1'b0};
        vecs[9] = '{8'h5A, 3'd0, 1'b1, 8'h5A, 1'b0, 1'b0};

        rst_i = 1'b1; en_i = 1'b1; in_valid_i = 1'b0; d_i = '0; shift_i = '0; rot_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        chk("reset_out",       32'(out_o),       32'h0);
        chk("reset_out_valid", 32'(out_valid_o), 32'h0);
        chk("reset_carry",     32'(carry_o),     32'h0);
        chk("reset_ovf",       32'(ovf_o),       32'h0);

        // T1 in isolation: a single-cycle out_valid pulse, flags hold afterwards.
        drive_x(1'b1, vecs[0].d, vecs[0].sh, vecs[0].rot, 1'b1,
                '{vecs[0].out, vecs[0].c, vecs[0].o, 0});
        idle(5);

        // Whole table back-to-back.
        for (int i = 0; i < 10; i++)
            drive_x(1'b1, vecs[i].d, vecs[i].sh, vecs[i].rot, 1'b1,
                    '{vecs[i].out, vecs[i].c, vecs[i].o, 0});
        idle(4);

        // T4: walking one, eight consecutive results.
        for (int i = 0; i < 8; i++) drive(1'b1, 8'h01, SHW'(i), 1'b0, 1'b1);
        idle(4);

        // T5: two stall cycles mid-stream (inputs ignored) and one bubble.
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                drive(1'b1, 8'hEE, 3'd5, 1'b0, 1'b0);
                drive(1'b1, 8'hEE, 3'd5, 1'b0, 1'b0);
            end
            if (i == 5) drive(1'b0, 8'h77, 3'd2, 1'b0, 1'b1);
            drive(1'b1, 8'h01, SHW'(i), 1'b0, 1'b1);
        end
        idle(4);

        // Random mix of enables, bubbles and modes.
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), SHW'($urandom),
                  1'($urandom), 1'($urandom_range(0, 4) != 0));
        idle(4);

        // T6: leave a non-zero result on the outputs, then reset with two in flight.
        drive(1'b1, 8'hFF, 3'd7, 1'b0, 1'b1);
        idle(4);
        drive(1'b1, 8'hC3, 3'd2, 1'b0, 1'b1);
        drive(1'b1, 8'h3C, 3'd6, 1'b1, 1'b1);
        rst_i = 1'b1;
        drive(1'b1, 8'hAA, 3'd1, 1'b0, 1'b1);
        rst_i = 1'b0;
        chk("rst_mid_out",       32'(out_o),       32'h0);
        chk("rst_mid_out_valid", 32'(out_valid_o), 32'h0);
        chk("rst_mid_carry",     32'(carry_o),     32'h0);
        chk("rst_mid_ovf",       32'(ovf_o),       32'h0);
        idle(6);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
